// File: rtl/pbr_read_arbiter.sv
// Round-robin arbiter sharing the packet-buffer read port among per-port deallocators.
// An in-order tag FIFO steers each read return back to the port that issued it.
module pbr_read_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PBR_SZ    = 16,
  parameter int unsigned PFW_SZ    = 32,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          dq_srdy,
  output logic [NUM_PORTS-1:0]          dq_drdy,
  input  logic [NUM_PORTS*PBR_SZ-1:0]   dq_data,
  output logic                          pbrd_srdy,
  input  logic                          pbrd_drdy,
  output logic [PBR_SZ-1:0]             pbrd_data,
  input  logic                          pbrr_srdy,
  output logic                          pbrr_drdy,
  input  logic [PFW_SZ-1:0]             pbrr_data,
  output logic [NUM_PORTS-1:0]          dr_srdy,
  input  logic [NUM_PORTS-1:0]          dr_drdy,
  output logic [PFW_SZ-1:0]             dr_data,
  output logic [$clog2(MAX_OUT):0]      outstanding,
  output logic                          orphan_err
);

  localparam int unsigned SEL_W = $clog2(NUM_PORTS);
  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SEL_W-1:0]  r_rr;
  logic [SEL_W-1:0]  r_tag [MAX_OUT];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_srdy;
  logic [PBR_SZ-1:0] r_data;
  logic              r_orphan;

  logic              w_hit;
  logic [SEL_W-1:0]  w_sel;
  logic [SEL_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_head;
  logic              w_empty;
  logic              w_pop;
  logic              w_free;
  logic              w_room;
  logic              w_grant;

  // First requester at or after the RR pointer; descending scan lets the nearest win.
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_rr;
    w_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = r_rr + SEL_W'(k);
      if (dq_srdy[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_empty   = (r_cnt == '0);
  assign w_head    = r_tag[r_rptr];
  assign pbrr_drdy = !w_empty && dr_drdy[w_head];
  assign w_pop     = pbrr_srdy && pbrr_drdy;
  assign dr_srdy   = (pbrr_srdy && !w_empty) ? (NUM_PORTS'(1) << w_head) : '0;
  assign dr_data   = pbrr_data;

  // A pop in the same cycle frees a tag slot, so a full FIFO can still take a grant.
  assign w_free  = !r_srdy || pbrd_drdy;
  assign w_room  = (r_cnt != CNT_W'(MAX_OUT)) || w_pop;
  assign w_grant = reset && w_free && w_room && w_hit;
  assign dq_drdy = w_grant ? (NUM_PORTS'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr     <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_srdy   <= 1'b0;
      r_data   <= '0;
      r_orphan <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) r_tag[i] <= '0;
    end else begin
      if (w_grant) begin
        r_srdy        <= 1'b1;
        r_data        <= dq_data[32'(w_sel) * PBR_SZ +: PBR_SZ];
        r_tag[r_wptr] <= w_sel;
        r_wptr        <= r_wptr + PTR_W'(1);
        r_rr          <= w_sel + SEL_W'(1);
      end else if (pbrd_drdy) begin
        r_srdy <= 1'b0;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_grant) - CNT_W'(w_pop);
      if (pbrr_srdy && w_empty) r_orphan <= 1'b1;
    end
  end

  assign pbrd_srdy   = r_srdy;
  assign pbrd_data   = r_data;
  assign outstanding = r_cnt;
  assign orphan_err  = r_orphan;

endmodule

// File: tb/tb_pbr_read_arbiter.sv
// Directed bench for pbr_read_arbiter; a negedge monitor scores request and return
// handshakes against queues filled by the stimulus sequence.
module tb_pbr_read_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned PB = 16;
  localparam int unsigned PF = 32;
  localparam int unsigned MO = 4;

  typedef struct packed {
    logic [1:0]    port;
    logic [PF-1:0] data;
  } ret_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     dq_srdy;
  logic [NP-1:0]     dq_drdy;
  logic [NP*PB-1:0]  dq_data;
  logic              pbrd_srdy;
  logic              pbrd_drdy;
  logic [PB-1:0]     pbrd_data;
  logic              pbrr_srdy;
  logic              pbrr_drdy;
  logic [PF-1:0]     pbrr_data;
  logic [NP-1:0]     dr_srdy;
  logic [NP-1:0]     dr_drdy;
  logic [PF-1:0]     dr_data;
  logic [$clog2(MO):0] outstanding;
  logic              orphan_err;

  int checks   = 0;
  int failures = 0;

  logic [PB-1:0] q_req [$];
  ret_t          q_ret [$];

  always #5 clk = ~clk;

  pbr_read_arbiter #(.NUM_PORTS(NP), .PBR_SZ(PB), .PFW_SZ(PF), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset),
    .dq_srdy(dq_srdy), .dq_drdy(dq_drdy), .dq_data(dq_data),
    .pbrd_srdy(pbrd_srdy), .pbrd_drdy(pbrd_drdy), .pbrd_data(pbrd_data),
    .pbrr_srdy(pbrr_srdy), .pbrr_drdy(pbrr_drdy), .pbrr_data(pbrr_data),
    .dr_srdy(dr_srdy), .dr_drdy(dr_drdy), .dr_data(dr_data),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    return NP'(1) << p;
  endfunction

  task automatic set_dq(input int p, input logic [PB-1:0] v);
    dq_data[p*PB +: PB] = v;
  endtask

  task automatic exp_ret(input int p, input logic [PF-1:0] d);
    ret_t r;
    r.port = 2'(p);
    r.data = d;
    q_ret.push_back(r);
  endtask

  // Handshakes complete at the next posedge; inputs and registered outputs are stable here.
  always @(negedge clk) begin
    logic [PB-1:0] er;
    ret_t          rt;
    #2;
    if (reset === 1'b1) begin
      if (pbrd_srdy && pbrd_drdy) begin
        chk("req_expected", 64'(q_req.size() != 0), 64'(1));
        if (q_req.size() != 0) begin
          er = q_req.pop_front();
          chk("req_data", 64'(pbrd_data), 64'(er));
        end
      end
      if (pbrr_srdy && pbrr_drdy) begin
        chk("ret_expected", 64'(q_ret.size() != 0), 64'(1));
        if (q_ret.size() != 0) begin
          rt = q_ret.pop_front();
          chk("ret_port", 64'(dr_srdy), 64'(onehot(int'(rt.port))));
          chk("ret_data", 64'(dr_data), 64'(rt.data));
        end
      end
    end
  end

  initial begin
    int ord [8];
    ord = '{3, 0, 1, 2, 3, 0, 1, 2};

    // Reset with requests and a return pending: nothing may be accepted or raised.
    reset = 1'b0; dq_srdy = '1; dq_data = '0; pbrd_drdy = 1'b0;
    pbrr_srdy = 1'b1; pbrr_data = '0; dr_drdy = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pbrd_srdy", 64'(pbrd_srdy), 64'(0));
    chk("rst_pbrd_data", 64'(pbrd_data), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_orphan", 64'(orphan_err), 64'(0));
    chk("rst_dq_drdy", 64'(dq_drdy), 64'(0));
    chk("rst_dr_srdy", 64'(dr_srdy), 64'(0));
    @(negedge clk);
    reset = 1'b1; dq_srdy = '0; pbrr_srdy = 1'b0; pbrd_drdy = 1'b1;

    // Single port request and return.
    @(negedge clk); dq_srdy = 4'b0100; set_dq(2, 16'h15); #1;
    chk("single_grant", 64'(dq_drdy), 64'(4'b0100));
    q_req.push_back(16'h15);
    @(negedge clk); dq_srdy = '0; #1;
    chk("single_srdy", 64'(pbrd_srdy), 64'(1));
    chk("single_data", 64'(pbrd_data), 64'(16'h15));
    chk("single_out1", 64'(outstanding), 64'(1));
    @(negedge clk); pbrr_srdy = 1'b1; pbrr_data = 32'hAB; #1;
    chk("single_dr_srdy", 64'(dr_srdy), 64'(4'b0100));
    chk("single_dr_data", 64'(dr_data), 64'(32'hAB));
    chk("single_pbrr_drdy", 64'(pbrr_drdy), 64'(1));
    chk("single_srdy_clr", 64'(pbrd_srdy), 64'(0));
    exp_ret(2, 32'hAB);
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("single_out0", 64'(outstanding), 64'(0));

    // Fairness: pointer sits at 3 after the port-2 grant.
    for (int p = 0; p < NP; p++) set_dq(p, PB'(16'hA0 + p));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dq_srdy = '1;
      if (i > 0) begin
        pbrr_srdy = 1'b1;
        pbrr_data = PF'(32'hC000 + i);
      end
      #1;
      chk("fair_grant", 64'(dq_drdy), 64'(onehot(ord[i])));
      q_req.push_back(PB'(16'hA0 + ord[i]));
      if (i > 0) exp_ret(ord[i-1], PF'(32'hC000 + i));
    end
    @(negedge clk); dq_srdy = '0; pbrr_data = 32'hC008; #1;
    chk("fair_last_ret", 64'(pbrr_drdy), 64'(1));
    exp_ret(ord[7], 32'hC008);
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("fair_out0", 64'(outstanding), 64'(0));

    // Tag FIFO full: four grants, then a pop re-opens a slot in the same cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); dq_srdy = 4'b0001; set_dq(0, PB'(16'hF0 + i)); #1;
      if (i < 4) begin
        chk("full_grant", 64'(dq_drdy), 64'(4'b0001));
        q_req.push_back(PB'(16'hF0 + i));
      end else begin
        chk("full_blocked", 64'(dq_drdy), 64'(0));
        chk("full_out4", 64'(outstanding), 64'(4));
      end
    end
    @(negedge clk); set_dq(0, 16'hF6); pbrr_srdy = 1'b1; pbrr_data = 32'hD0; #1;
    chk("full_pop_grant", 64'(dq_drdy), 64'(4'b0001));
    chk("full_pop_drdy", 64'(pbrr_drdy), 64'(1));
    q_req.push_back(16'hF6);
    exp_ret(0, 32'hD0);
    @(negedge clk); dq_srdy = '0; pbrr_srdy = 1'b0; #1;
    chk("full_out_hold", 64'(outstanding), 64'(4));
    chk("full_fifth_srdy", 64'(pbrd_srdy), 64'(1));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); pbrr_srdy = 1'b1; pbrr_data = PF'(32'hD0 + i); #1;
      exp_ret(0, PF'(32'hD0 + i));
    end
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("full_out0", 64'(outstanding), 64'(0));

    // Ordering with head back-pressure; pointer is at 1.
    @(negedge clk); dq_srdy = 4'b1000; set_dq(3, 16'h31); #1;
    chk("ord_g0", 64'(dq_drdy), 64'(4'b1000));
    q_req.push_back(16'h31);
    @(negedge clk); dq_srdy = 4'b0010; set_dq(1, 16'h11); #1;
    chk("ord_g1", 64'(dq_drdy), 64'(4'b0010));
    q_req.push_back(16'h11);
    @(negedge clk); dq_srdy = 4'b1000; set_dq(3, 16'h32); #1;
    chk("ord_g2", 64'(dq_drdy), 64'(4'b1000));
    q_req.push_back(16'h32);
    @(negedge clk); dq_srdy = '0; #1;
    chk("ord_out3", 64'(outstanding), 64'(3));
    @(negedge clk); pbrr_srdy = 1'b1; pbrr_data = 32'hE0; #1;
    chk("ord_r0_port", 64'(dr_srdy), 64'(4'b1000));
    exp_ret(3, 32'hE0);
    @(negedge clk); pbrr_data = 32'hE1; dr_drdy = 4'b1101; #1;
    chk("ord_stall_drdy", 64'(pbrr_drdy), 64'(0));
    chk("ord_stall_srdy", 64'(dr_srdy), 64'(4'b0010));
    @(negedge clk); #1;
    chk("ord_stall_drdy2", 64'(pbrr_drdy), 64'(0));
    chk("ord_stall_out2", 64'(outstanding), 64'(2));
    @(negedge clk); dr_drdy = '1; #1;
    chk("ord_release", 64'(pbrr_drdy), 64'(1));
    exp_ret(1, 32'hE1);
    @(negedge clk); pbrr_data = 32'hE2; #1;
    chk("ord_r2_port", 64'(dr_srdy), 64'(4'b1000));
    exp_ret(3, 32'hE2);
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("ord_out0", 64'(outstanding), 64'(0));

    // Output-stage back-pressure: held word stays stable, no further grants.
    @(negedge clk); pbrd_drdy = 1'b0; dq_srdy = 4'b0100; set_dq(2, 16'h55); #1;
    chk("bp_grant", 64'(dq_drdy), 64'(4'b0100));
    q_req.push_back(16'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); set_dq(2, 16'h66); #1;
      chk("bp_srdy", 64'(pbrd_srdy), 64'(1));
      chk("bp_data", 64'(pbrd_data), 64'(16'h55));
      chk("bp_no_grant", 64'(dq_drdy), 64'(0));
    end
    chk("bp_out1", 64'(outstanding), 64'(1));
    @(negedge clk); pbrd_drdy = 1'b1; #1;
    chk("bp_rel_grant", 64'(dq_drdy), 64'(4'b0100));
    q_req.push_back(16'h66);
    @(negedge clk); dq_srdy = '0; #1;
    chk("bp_next_srdy", 64'(pbrd_srdy), 64'(1));
    chk("bp_next_data", 64'(pbrd_data), 64'(16'h66));
    chk("bp_out2", 64'(outstanding), 64'(2));
    @(negedge clk); pbrr_srdy = 1'b1; pbrr_data = 32'hF1; #1;
    exp_ret(2, 32'hF1);
    @(negedge clk); pbrr_data = 32'hF2; #1;
    exp_ret(2, 32'hF2);
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("bp_out0", 64'(outstanding), 64'(0));
    chk("bp_srdy_clr", 64'(pbrd_srdy), 64'(0));

    // Orphan return, then asynchronous reset in the middle of a burst.
    @(negedge clk); pbrr_srdy = 1'b1; pbrr_data = 32'h99; #1;
    chk("orph_drdy", 64'(pbrr_drdy), 64'(0));
    chk("orph_dr_srdy", 64'(dr_srdy), 64'(0));
    chk("orph_pre", 64'(orphan_err), 64'(0));
    @(negedge clk); pbrr_srdy = 1'b0; #1;
    chk("orph_set", 64'(orphan_err), 64'(1));
    @(negedge clk); #1;
    chk("orph_sticky", 64'(orphan_err), 64'(1));
    @(negedge clk); pbrd_drdy = 1'b0; dq_srdy = '1; #1;
    chk("burst_grant", 64'(dq_drdy), 64'(4'b1000));
    @(negedge clk); #1;
    chk("burst_srdy", 64'(pbrd_srdy), 64'(1));
    chk("burst_out1", 64'(outstanding), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("arst_srdy", 64'(pbrd_srdy), 64'(0));
    chk("arst_data", 64'(pbrd_data), 64'(0));
    chk("arst_out", 64'(outstanding), 64'(0));
    chk("arst_orphan", 64'(orphan_err), 64'(0));
    chk("arst_dq_drdy", 64'(dq_drdy), 64'(0));
    @(negedge clk); reset = 1'b1; #1;
    chk("arst_rr_ptr0", 64'(dq_drdy), 64'(4'b0001));
    @(negedge clk); dq_srdy = '0; #3;
    chk("req_q_drained", 64'(q_req.size()), 64'(0));
    chk("ret_q_drained", 64'(q_ret.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pbr_read_arbiter.md
Name: pbr_read_arbiter

Overview:
Shares the single packet-buffer read request port between the NUM_PORTS per-port deallocators. Each cycle it round-robin arbitrates one read request into a registered output stage toward the packet buffer. It records the granted port in an in-order tag FIFO and routes each in-order read return from the packet buffer back to the deallocator that issued it. It sits between the deallocator array and the packet buffer read/return interfaces.

Parameters:
NUM_PORTS, 4, number of requesting deallocators (power of 2, ≥2)
PBR_SZ, `PBR_SZ, width of a packet-buffer request word
PFW_SZ, `PFW_SZ, width of a packet-buffer return word
MAX_OUT, 4, maximum outstanding reads (tag FIFO depth, power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
dq_srdy  in  NUM_PORTS  per-port read request valid
dq_drdy  out  NUM_PORTS  per-port read request accept
dq_data  in  NUM_PORTS*PBR_SZ  per-port request words, port i at [i*PBR_SZ +: PBR_SZ]
pbrd_srdy  out  1  request valid to packet buffer
pbrd_drdy  in  1  packet buffer accepts request
pbrd_data  out  PBR_SZ  granted request word
pbrr_srdy  in  1  read return valid from packet buffer
pbrr_drdy  out  1  read return accept
pbrr_data  in  PFW_SZ  read return word
dr_srdy  out  NUM_PORTS  per-port return valid
dr_drdy  in  NUM_PORTS  per-port return accept
dr_data  out  PFW_SZ  return word (broadcast to all ports; qualified by dr_srdy)
outstanding  out  log2(MAX_OUT)+1  reads granted but not yet returned
orphan_err  out  1  sticky: return arrived with no outstanding tag

Behaviour:
- Reset (asynchronous assert, reset low): pbrd_srdy=0, pbrd_data=0, tag FIFO empty, outstanding=0, orphan_err=0, RR pointer=0. All dq_drdy=0 and dr_srdy=0 while reset is low. Reset mid-operation drops all in-flight tags; deallocators are reset together with this block.
- Output stage: one register. It is "free" when pbrd_srdy=0 or (pbrd_srdy & pbrd_drdy) in the same cycle.
- Grant: when the output stage is free and the FIFO is not full (count<MAX_OUT, or count==MAX_OUT with a pop this cycle), select the first requesting port at or after the RR pointer (wrap modulo NUM_PORTS). Assert dq_drdy only for that port; all others are 0. This logic is combinational and depends on dq_srdy.
- On grant: pbrd_data<=dq_data[sel], pbrd_srdy<=1 next cycle (1-cycle latency), push sel into the tag FIFO, RR pointer<=sel+1 mod NUM_PORTS. The pointer is unchanged when there is no grant.
- pbrd_srdy/pbrd_data hold stable until pbrd_drdy. If no new grant occurs in the acceptance cycle, pbrd_srdy clears the next cycle.
- Request word passes through unmodified, including the PBR_PORT field. The tag FIFO, not PBR_PORT, determines return routing.
- Return routing: the packet buffer returns in request order.
  - dr_srdy[i] = pbrr_srdy & FIFO non-empty & head==i.
  - pbrr_drdy = FIFO non-empty & dr_drdy[head].
  - dr_data = pbrr_data (combinational, zero latency).
  - Pop the FIFO on pbrr_srdy & pbrr_drdy.
- outstanding = FIFO count. Push and pop in the same cycle leave the count unchanged. Push occurs at grant time, so outstanding includes a request still held in the output stage.
- FIFO full (count==MAX_OUT, no pop this cycle): no grant; all dq_drdy=0. Existing pbrd_srdy still presents.
- Empty FIFO with pbrr_srdy=1: pbrr_drdy=0, dr_srdy=0, orphan_err<=1 (sticky until reset).
- Single requester: granted back-to-back every cycle while pbrd_drdy=1 and the FIFO has room.
- Head port back-pressure (dr_drdy[head]=0) stalls all returns. There is no reordering.

Test Plan:
- Single port: port 2 requests with data 0x15, pbrd_drdy=1 → pbrd_srdy rises 1 cycle after the dq_drdy[2] pulse with pbrd_data=0x15. Return 0xAB → dr_srdy=4'b0100, dr_data=0xAB, outstanding 1→0.
- Fairness: all 4 ports request continuously, pbrd_drdy=1, returns prompt → grant order 0,1,2,3,0,1… with no port granted twice before the others.
- Full: pbrd_drdy=1, no returns, port 0 requests 6 times → exactly 4 grants, outstanding=4, dq_drdy=0. One return → a 5th grant occurs in the cycle of the pop.
- Ordering: grants go to ports 3,1,3. Returns R0,R1,R2 go to ports 3,1,3 respectively. With dr_drdy[1]=0 during R1, pbrr_drdy=0 and R2 is not delivered until dr_drdy[1]=1.
- Back-pressure: pbrd_drdy=0 for 5 cycles with pbrd_srdy=1 → pbrd_data is stable and only one grant is recorded. Release → the next grant is presented the following cycle.
- Orphan and reset: pbrr_srdy=1 with the FIFO empty → orphan_err=1 next cycle and pbrr_drdy=0. Assert reset low mid-burst → outputs clear immediately (asynchronously) and orphan_err=0.
